// File: rtl/if_fetch_ctrl_if.sv
// Fetch-controller bus: debug/hazard requests, instruction memory read data,
// and the PC, IF/ID, advance and statistics outputs.
interface if_fetch_ctrl_if #(
  parameter int N_BITS   = 32,
  parameter int CNT_BITS = 32
);
  logic                i_enable;
  logic                i_step_mode;
  logic                i_step;
  logic                i_halt;
  logic                i_flush;
  logic [N_BITS-1:0]   i_jump_direction;
  logic [N_BITS-1:0]   i_imem_data;

  logic [N_BITS-1:0]   o_pc;
  logic [N_BITS-1:0]   o_if_id_instr;
  logic [N_BITS-1:0]   o_if_id_pc4;
  logic                o_if_id_valid;
  logic                o_advance;
  logic                o_program_end;
  logic [CNT_BITS-1:0] o_cycle_count;
  logic [CNT_BITS-1:0] o_stall_count;
  logic [CNT_BITS-1:0] o_flush_count;

  // Driven by the debug unit, hazard logic and instruction memory.
  modport master (
    output i_enable, i_step_mode, i_step, i_halt, i_flush,
           i_jump_direction, i_imem_data,
    input  o_pc, o_if_id_instr, o_if_id_pc4, o_if_id_valid, o_advance,
           o_program_end, o_cycle_count, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_enable, i_step_mode, i_step, i_halt, i_flush,
           i_jump_direction, i_imem_data,
    output o_pc, o_if_id_instr, o_if_id_pc4, o_if_id_valid, o_advance,
           o_program_end, o_cycle_count, o_stall_count, o_flush_count
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage controller: PC register, IF/ID register, run/step/drain sequencing.
// Optional stall/flush statistics counters are built when IF_FETCH_STATS_EN is defined.
module if_fetch_ctrl #(
  parameter int                N_BITS       = 32,
  parameter logic [N_BITS-1:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int                DRAIN_CYCLES = 4,
  parameter int                CNT_BITS     = 32,
  parameter logic [N_BITS-1:0] PC_RESET     = '0
) (
  input logic              i_clk,
  input logic              i_reset,
  if_fetch_ctrl_if.slave   bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [N_BITS-1:0]  PC_STEP   = N_BITS'(4);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_END   = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [N_BITS-1:0]   pc_q, pc_d;
  logic [N_BITS-1:0]   instr_q, instr_d;
  logic [N_BITS-1:0]   pc4_q, pc4_d;
  logic                valid_q, valid_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CNT_BITS-1:0] cycle_q, cycle_d;
  logic                adv;
  logic [N_BITS-1:0]   pc_plus4;
  logic [DRAIN_W-1:0]  drain_inc;

  assign pc_plus4  = pc_q + PC_STEP;
  assign drain_inc = drain_q + 1'b1;

  // Single clock-enable for the whole pipeline; forced low while in reset.
  assign adv = !i_reset
             && (state_q == ST_RUN || state_q == ST_DRAIN)
             && bus.i_enable
             && (!mode_q || bus.i_step);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
    end
  end

  // NOTE: every output of this block gets a hold default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    drain_d = drain_q;
    cycle_d = cycle_q;

    if (adv && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_enable) begin
          mode_d  = bus.i_step_mode;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // A stalled branch is re-evaluated after the stall, so halt beats flush.
        if (adv && !bus.i_halt) begin
          if (bus.i_flush) begin
            pc_d    = bus.i_jump_direction;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else if (bus.i_imem_data == HALT_INSTR) begin
            instr_d = HALT_INSTR;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            pc_d    = pc_plus4;
            instr_d = bus.i_imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (adv && !bus.i_halt) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          drain_d = drain_inc;
          if (drain_inc == DRAIN_END) state_d = ST_END;
        end
      end

      ST_END: begin
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_if_id_instr = instr_q;
  assign bus.o_if_id_pc4   = pc4_q;
  assign bus.o_if_id_valid = valid_q;
  assign bus.o_advance     = adv;
  assign bus.o_program_end = (state_q == ST_END);
  assign bus.o_cycle_count = cycle_q;

`ifdef IF_FETCH_STATS_EN
  logic [CNT_BITS-1:0] stall_q;
  logic [CNT_BITS-1:0] flush_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (adv && bus.i_halt && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (adv && (state_q == ST_RUN) && bus.i_flush && !bus.i_halt && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.o_stall_count = stall_q;
  assign bus.o_flush_count = flush_q;
`else
  assign bus.o_stall_count = '0;
  assign bus.o_flush_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch sequencing rules.
module tb_if_fetch_ctrl;

  localparam int          N_BITS  = 32;
  localparam int          CNT_W   = 8;
  localparam int          DRAIN_N = 4;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;
  localparam int          SAT     = (1 << CNT_W) - 1;
  localparam logic [31:0] NO_HALT = 32'hFFFF_FFF0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.N_BITS(N_BITS), .CNT_BITS(CNT_W)) bus ();

  if_fetch_ctrl #(
    .N_BITS      (N_BITS),
    .HALT_INSTR  (HALT),
    .DRAIN_CYCLES(DRAIN_N),
    .CNT_BITS    (CNT_W),
    .PC_RESET    (32'h0)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Instruction memory: a scrambled word per address (top bit clear so it is
  // never HALT), except at halt_addr which returns HALT.
  logic [31:0] halt_addr = NO_HALT;

  function automatic logic [31:0] scramble(input logic [31:0] a);
    return ((a * 32'h9E37_79B9) ^ 32'h2468_ACE0) & 32'h7FFF_FFFF;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
    return (a == h) ? HALT : scramble(a);
  endfunction

  always_comb bus.i_imem_data = (bus.o_pc == halt_addr) ? HALT : scramble(bus.o_pc);

  // Reference model: 0 idle, 1 run, 2 drain, 3 end.
  int          m_phase;
  bit          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  int          m_drain, m_cyc, m_stall, m_flush;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_adv();
    return !reset && (m_phase == 1 || m_phase == 2) && bus.i_enable
           && (!m_mode || bus.i_step);
  endfunction

  task automatic model_nop();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_update(input bit a);
    logic [31:0] w;
    if (reset) begin
      m_phase = 0; m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_drain = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (m_phase == 0) begin
      if (bus.i_enable) begin
        m_mode  = bus.i_step_mode;
        m_phase = 1;
      end
      return;
    end
    if (!a) return;
    if (m_cyc < SAT) m_cyc++;
    if (bus.i_halt) begin
      if (m_stall < SAT) m_stall++;
      return;
    end
    if (m_phase == 1) begin
      if (bus.i_flush) begin
        if (m_flush < SAT) m_flush++;
        m_pc = bus.i_jump_direction;
        model_nop();
      end else begin
        w = mem_word(m_pc, halt_addr);
        m_instr = w;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        if (w == HALT) begin
          m_drain = 0;
          m_phase = 2;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      model_nop();
      m_drain++;
      if (m_drain == DRAIN_N) m_phase = 3;
    end
  endtask

  task automatic check_outputs();
    check("pc",          bus.o_pc,          m_pc);
    check("if_id_instr", bus.o_if_id_instr, m_instr);
    check("if_id_pc4",   bus.o_if_id_pc4,   m_pc4);
    check("if_id_valid", bus.o_if_id_valid, m_valid);
    check("program_end", bus.o_program_end, m_phase == 3);
    check("cycle_count", bus.o_cycle_count, m_cyc);
`ifdef IF_FETCH_STATS_EN
    check("stall_count", bus.o_stall_count, m_stall);
    check("flush_count", bus.o_flush_count, m_flush);
`else
    check("stall_count", bus.o_stall_count, 0);
    check("flush_count", bus.o_flush_count, 0);
`endif
  endtask

  // Inputs are set just after a posedge; advance is checked mid-cycle and all
  // registered outputs 1 time unit after the next posedge.
  task automatic tick();
    bit a;
    #1;
    a = model_adv();
    check("advance", bus.o_advance, a);
    @(posedge clk);
    model_update(a);
    #1;
    check_outputs();
  endtask

  task automatic set_in(input bit en, input bit sm, input bit st, input bit h,
                        input bit f, input logic [31:0] jd);
    bus.i_enable         = en;
    bus.i_step_mode      = sm;
    bus.i_step           = st;
    bus.i_halt           = h;
    bus.i_flush          = f;
    bus.i_jump_direction = jd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    m_phase = 0; m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_drain = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    do_reset();
    tick();                                   // idle with enable low

    // Continuous run from reset.
    set_in(1, 0, 0, 0, 0, 0);
    tick();                                   // IDLE -> RUN, no advance
    repeat (2) tick();                        // pc 4, 8
    check("pc_at_8", bus.o_pc, 32'd8);

    // Load-use stall for two cycles, then resume.
    set_in(1, 0, 0, 1, 0, 0);
    repeat (2) tick();
    set_in(1, 0, 0, 0, 0, 0);
    tick();                                   // pc 12

    // Flush with a simultaneous stall is ignored, then a real redirect.
    set_in(1, 0, 0, 1, 1, 32'h40);
    tick();
    set_in(1, 0, 0, 0, 1, 32'h40);
    tick();
    check("redirect_pc", bus.o_pc, 32'h40);

    // HALT at 0x44: drain with one stall inside, then END frozen.
    halt_addr = 32'h44;
    set_in(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    set_in(1, 0, 0, 1, 1, 32'h80);
    tick();
    set_in(1, 0, 0, 0, 1, 32'h80);
    repeat (5) tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 1, 0, 0, 0);
    tick();

    // Reset in the middle of DRAIN.
    do_reset();
    halt_addr = 32'h8;
    set_in(1, 0, 0, 0, 0, 0);
    repeat (5) tick();
    do_reset();

    // Single-step: three pulses over ten cycles.
    halt_addr = NO_HALT;
    set_in(1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 1, (i == 1 || i == 4 || i == 8), 0, 0, 0);
      tick();
    end
    check("step_pc", bus.o_pc, 32'd12);

    // PC wrap at the top of the address space, then a long run to saturate.
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 1, 32'hFFFF_FFF8);
    tick();
    for (int i = 0; i < 300; i++) begin
      set_in(1, 0, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
             {$urandom_range(0, 127), 2'b00});
      tick();
    end

    // Randomized traffic with occasional resets and HALT placements.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0 || (m_phase == 3 && $urandom_range(0, 7) == 0)) begin
        do_reset();
        halt_addr = ($urandom_range(0, 1) == 0) ? NO_HALT : {$urandom_range(0, 127), 2'b00};
      end
      set_in(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
             $urandom_range(0, 1), ($urandom_range(0, 6) == 0),
             ($urandom_range(0, 6) == 0), {$urandom_range(0, 127), 2'b00});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-side consumer of the stall/flush/jump-target signals produced by the ID-stage hazard logic.
- Owns the PC register, drives the instruction-memory address, and owns the IF/ID pipeline register.
- Converts stall/flush/redirect requests into PC and IF/ID updates.
- Sequences program start, debug single-step, HALT-instruction drain and end-of-program under control of the debug unit.

Parameters:
- N_BITS, 32, data/address width.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that terminates the program.
- DRAIN_CYCLES, 4, advances after HALT fetch before end-of-program is declared.
- CNT_BITS, 32, width of cycle/stat counters.
- PC_RESET, 0, PC value after reset.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug unit run gate; no advance while 0.
- i_step_mode  in  1  sampled on IDLE->RUN: 1 = single-step, 0 = continuous.
- i_step  in  1  one-cycle pulse; permits one advance in step mode.
- i_halt  in  1  stall request from hazard detection (load-use).
- i_flush  in  1  taken branch/jump request.
- i_jump_direction  in  N_BITS  redirect target, valid with i_flush.
- i_imem_data  in  N_BITS  instruction at o_pc (asynchronous-read memory).
- o_pc  out  N_BITS  current PC / instruction memory address.
- o_if_id_instr  out  N_BITS  IF/ID instruction.
- o_if_id_pc4  out  N_BITS  IF/ID PC+4.
- o_if_id_valid  out  1  IF/ID holds a real instruction.
- o_advance  out  1  combinational; downstream pipeline registers clock-enable.
- o_program_end  out  1  program finished.
- o_cycle_count  out  CNT_BITS  advances since start.
- o_stall_count  out  CNT_BITS  see Optional Feature.
- o_flush_count  out  CNT_BITS  see Optional Feature.

Behaviour:
- Reset values:
  - State IDLE, mode bit 0.
  - o_pc = PC_RESET, o_if_id_instr = 0 (NOP), o_if_id_pc4 = 0, o_if_id_valid = 0.
  - o_program_end = 0, all counters 0, drain counter 0.
  - o_advance = 0 while i_reset = 1.
- States: IDLE(00), RUN(01), DRAIN(10), END(11).
- IDLE: nothing moves. On i_enable = 1, latch mode = i_step_mode and go to RUN next edge. No advance in that transition cycle.
- adv = (state RUN or DRAIN) && i_enable && (mode == 0 || i_step). o_advance = adv.
- RUN, per adv cycle, first match wins:
  - i_halt = 1: PC and IF/ID held; any simultaneous i_flush is ignored, because the branch is re-evaluated after the stall.
  - i_flush = 1: PC <= i_jump_direction; IF/ID <= NOP, valid 0. A concurrently fetched HALT_INSTR is discarded.
  - i_imem_data == HALT_INSTR: IF/ID <= {HALT_INSTR, PC+4}, valid 1; PC held; drain counter <= 0; go to DRAIN.
  - Otherwise: PC <= PC+4 (modulo 2^N_BITS wrap); IF/ID <= {i_imem_data, PC+4}, valid 1.
- DRAIN, per adv cycle:
  - i_halt = 1: hold everything; drain counter does not increment.
  - Otherwise: IF/ID <= NOP, valid 0; drain counter + 1. When it reaches DRAIN_CYCLES, go to END.
  - i_flush ignored; PC frozen.
- END: o_program_end = 1; adv = 0; all registers frozen until i_reset. i_enable is ignored.
- No adv (i_enable = 0, or step mode without i_step): all registers hold, including counters.
- o_cycle_count: +1 on every adv cycle, saturates at all-ones.
- Reset mid-operation (any state): next edge returns all outputs to reset values.

Optional Feature:
- Macro: IF_FETCH_STATS_EN.
- Defined:
  - o_stall_count +1 on adv cycles with i_halt = 1.
  - o_flush_count +1 on adv cycles in RUN with i_flush = 1 and i_halt = 0.
  - Both saturate and reset to 0.
- Undefined: both ports are constant 0 and no counter registers are built.

Test Plan:
1. Reset; i_enable = 1, i_step_mode = 0; memory returns non-HALT words.
   -> o_pc 0, 4, 8, ...; o_if_id_pc4 4, 8, ...; valid 1; o_advance 1 every cycle; o_cycle_count increments by 1 per cycle.
2. At o_pc = 8, i_halt = 1 for 2 cycles.
   -> o_pc stays 8 and IF/ID unchanged for 2 cycles, then o_pc = 12. o_cycle_count +2; o_stall_count = 2 with the macro, 0 without.
3. At o_pc = 12, i_flush = 1, i_jump_direction = 0x40.
   -> next o_pc = 0x40, o_if_id_instr = 0, valid 0.
   Repeat with i_halt = 1 in the same cycle -> o_pc stays 12.
4. Memory returns HALT_INSTR at 0x44.
   -> IF/ID = HALT, o_pc stays 0x44; 4 NOP advances follow; o_program_end = 1; o_advance = 0; o_cycle_count frozen.
5. Step mode; 3 i_step pulses spread over 10 cycles.
   -> o_pc ends at 12; o_advance high exactly on the 3 pulse cycles.
6. i_reset during DRAIN.
   -> next edge: o_pc = 0, valid 0, o_program_end = 0, counters 0, state IDLE.
